// File: rtl/div_pkg.sv
// Shared definitions for the iterative signed divider: state encoding,
// default operand width and the signed limit values derived from a width.
package div_pkg;

  localparam int SIZE_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  // Most negative two's complement value of the given width, zero-extended to 64 bits.
  function automatic logic [63:0] min_val(input int size);
    return 64'(1) << (size - 1);
  endfunction

  function automatic logic [63:0] max_val(input int size);
    return (64'(1) << (size - 1)) - 64'(1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift the next dividend bit into
// the partial remainder and subtract the divisor magnitude when it fits.
module div_step #(
  parameter int SIZE = 16
) (
  input  logic [SIZE:0] r_i,
  input  logic [SIZE:0] bmag_i,
  input  logic          bit_i,
  output logic [SIZE:0] r_next_o,
  output logic          q_bit_o
);

  logic [SIZE+1:0] r_shift;
  logic [SIZE+1:0] b_ext;

  always_comb begin
    r_shift  = {r_i, bit_i};
    b_ext    = {1'b0, bmag_i};
    q_bit_o  = (r_shift >= b_ext);
    r_next_o = (SIZE+1)'(q_bit_o ? (r_shift - b_ext) : r_shift);
  end

endmodule

// File: rtl/div_iter.sv
// Iterative signed restoring divider: one quotient bit per cycle, MSB first,
// truncating toward zero. Define DIV_REMAINDER_EN to add the signed rem output.
module div_iter
  import div_pkg::*;
#(
  parameter int SIZE  = SIZE_DEF,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SIZE-1:0] q,
  output logic            div0,
  output logic            ovf
`ifdef DIV_REMAINDER_EN
  ,
  output logic [SIZE-1:0] rem
`endif
);

  localparam logic [SIZE-1:0]  MIN_V    = SIZE'(min_val(SIZE));
  localparam logic [SIZE-1:0]  MAX_V    = SIZE'(max_val(SIZE));
  localparam logic [SIZE-1:0]  NEG1_V   = '1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SIZE - 1);

  div_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [SIZE-1:0]  dvd_q;
  logic [SIZE:0]    bmag_q;
  logic [SIZE:0]    r_q;
  logic [SIZE-1:0]  quo_q;
  logic             sgnq_q;
  logic             sgnr_q;
  logic [SIZE-1:0]  q_q;
  logic             div0_q;
  logic             ovf_q;
  logic             out_valid_q;

  logic [SIZE-1:0]  amag_d;
  logic [SIZE:0]    b_ext;
  logic [SIZE:0]    bmag_d;
  logic [SIZE:0]    r_next;
  logic             q_bit;
  logic [SIZE-1:0]  q_d;

`ifdef DIV_REMAINDER_EN
  logic [SIZE-1:0]  rem_q;
  logic [SIZE-1:0]  rem_d;
`endif

  // |MIN| still fits in SIZE unsigned bits, so the dividend shifter needs no extra bit.
  always_comb begin
    amag_d = a[SIZE-1] ? -a : a;
    b_ext  = {b[SIZE-1], b};
    bmag_d = b[SIZE-1] ? -b_ext : b_ext;
  end

  div_step #(
    .SIZE (SIZE)
  ) u_step (
    .r_i      (r_q),
    .bmag_i   (bmag_q),
    .bit_i    (dvd_q[SIZE-1]),
    .r_next_o (r_next),
    .q_bit_o  (q_bit)
  );

  // With a zero divisor every step keeps the shifted remainder, so r ends up
  // holding |a| and the sign fix below reproduces a as the remainder.
  always_comb begin
    if (div0_q) begin
      q_d = sgnr_q ? MIN_V : MAX_V;
    end else begin
      q_d = sgnq_q ? -quo_q : quo_q;
    end
`ifdef DIV_REMAINDER_EN
    rem_d = sgnr_q ? -r_q[SIZE-1:0] : r_q[SIZE-1:0];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dvd_q       <= '0;
      bmag_q      <= '0;
      r_q         <= '0;
      quo_q       <= '0;
      sgnq_q      <= 1'b0;
      sgnr_q      <= 1'b0;
      q_q         <= '0;
      div0_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef DIV_REMAINDER_EN
      rem_q       <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            dvd_q   <= amag_d;
            bmag_q  <= bmag_d;
            r_q     <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            sgnq_q  <= a[SIZE-1] ^ b[SIZE-1];
            sgnr_q  <= a[SIZE-1];
            div0_q  <= (b == '0);
            ovf_q   <= (a == MIN_V) && (b == NEG1_V);
            state_q <= CALC;
          end
        end
        CALC: begin
          r_q   <= r_next;
          quo_q <= {quo_q[SIZE-2:0], q_bit};
          dvd_q <= {dvd_q[SIZE-2:0], 1'b0};
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          q_q         <= q_d;
`ifdef DIV_REMAINDER_EN
          rem_q       <= rem_d;
`endif
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign q         = q_q;
  assign div0      = div0_q;
  assign ovf       = ovf_q;
`ifdef DIV_REMAINDER_EN
  assign rem       = rem_q;
`endif

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: directed corner cases, backpressure, async
// reset, throughput and random operands against a plain-arithmetic model.
`timescale 1ns/1ps
module tb_div_iter;

  localparam int SIZE = 16;
  localparam int LAT  = SIZE + 2;
  localparam int PER  = SIZE + 3;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic [15:0] r;
    logic        d0;
    logic        ov;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] q;
  logic        div0;
  logic        ovf;
`ifdef DIV_REMAINDER_EN
  logic [15:0] rem;
`endif

  int checks = 0;
  int errors = 0;

  div_iter #(
    .SIZE  (SIZE),
    .CNT_W (5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q),
    .div0      (div0),
    .ovf       (ovf)
`ifdef DIV_REMAINDER_EN
    ,
    .rem       (rem)
`endif
  );

  always #5 clk = ~clk;

  // Reference: C-style signed division (truncate toward zero, remainder takes sign of a).
  function automatic void ref_div(input logic [15:0] av, input logic [15:0] bv,
                                  output logic [15:0] eq, output logic [15:0] er,
                                  output logic ed0, output logic eov);
    int ai;
    int bi;
    ai  = int'($signed(av));
    bi  = int'($signed(bv));
    ed0 = (bi == 0);
    eov = (ai == -32768) && (bi == -1);
    if (ed0) begin
      eq = (ai >= 0) ? 16'h7FFF : 16'h8000;
      er = av;
    end else if (eov) begin
      eq = 16'h8000;
      er = 16'h0000;
    end else begin
      eq = 16'(ai / bi);
      er = 16'(ai % bi);
    end
  endfunction

  // Drives one operation, measures edges from the accepting edge (counted as 1)
  // to the first edge after which out_valid is high, then consumes the result.
  task automatic run_op(input logic [15:0] av, input logic [15:0] bv, input int stall,
                        output int lat, output logic [15:0] qo, output logic [15:0] ro,
                        output logic d0o, output logic ovo);
    int n;
    @(negedge clk);
    a = av;
    b = bv;
    in_valid = 1'b1;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    repeat (stall) @(posedge clk);
    @(negedge clk);
    qo  = q;
    d0o = div0;
    ovo = ovf;
`ifdef DIV_REMAINDER_EN
    ro = rem;
`else
    ro = 16'h0000;
`endif
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_hs: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
    checks++;
    if (q !== 16'h0 || div0 !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_out: q=%h div0=%b ovf=%b expected 0000/0/0", q, div0, ovf);
    end
`ifdef DIV_REMAINDER_EN
    checks++;
    if (rem !== 16'h0) begin
      errors++;
      $display("[TB] FAIL reset_rem: rem=%h expected 0000", rem);
    end
`endif
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_table(input string name, input vec_t tbl[$]);
    int lat;
    logic [15:0] qo;
    logic [15:0] ro;
    logic d0o;
    logic ovo;
    foreach (tbl[i]) begin
      run_op(tbl[i].a, tbl[i].b, 0, lat, qo, ro, d0o, ovo);
      checks++;
      if (qo !== tbl[i].q) begin
        errors++;
        $display("[TB] FAIL %s_q[%0d]: got %h expected %h", name, i, qo, tbl[i].q);
      end
      checks++;
      if (d0o !== tbl[i].d0 || ovo !== tbl[i].ov) begin
        errors++;
        $display("[TB] FAIL %s_flags[%0d]: div0=%b ovf=%b expected %b/%b", name, i, d0o, ovo, tbl[i].d0, tbl[i].ov);
      end
      checks++;
      if (lat !== LAT) begin
        errors++;
        $display("[TB] FAIL %s_latency[%0d]: got %0d expected %0d", name, i, lat, LAT);
      end
`ifdef DIV_REMAINDER_EN
      checks++;
      if (ro !== tbl[i].r) begin
        errors++;
        $display("[TB] FAIL %s_rem[%0d]: got %h expected %h", name, i, ro, tbl[i].r);
      end
`endif
    end
  endtask

  task automatic test_basic();
    vec_t tbl[$];
    tbl.push_back('{16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 1'b0});
    run_table("basic", tbl);
  endtask

  task automatic test_signs();
    vec_t tbl[$];
    tbl.push_back('{16'hFF9C, 16'h0007, 16'hFFF2, 16'hFFFE, 1'b0, 1'b0});
    tbl.push_back('{16'h0064, 16'hFFF9, 16'hFFF2, 16'h0002, 1'b0, 1'b0});
    tbl.push_back('{16'hFF9C, 16'hFFF9, 16'h000E, 16'hFFFE, 1'b0, 1'b0});
    run_table("signs", tbl);
  endtask

  task automatic test_limits();
    vec_t tbl[$];
    tbl.push_back('{16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, 1'b1});
    tbl.push_back('{16'h8000, 16'h0001, 16'h8000, 16'h0000, 1'b0, 1'b0});
    tbl.push_back('{16'h0005, 16'h0000, 16'h7FFF, 16'h0005, 1'b1, 1'b0});
    tbl.push_back('{16'hFFFB, 16'h0000, 16'h8000, 16'hFFFB, 1'b1, 1'b0});
    run_table("limits", tbl);
  endtask

  task automatic test_backpressure();
    logic [15:0] eq;
    logic [15:0] er;
    logic ed0;
    logic eov;
    int n;
    ref_div(16'd1234, 16'hFFC8, eq, er, ed0, eov);
    @(negedge clk);
    a = 16'd1234;
    b = 16'hFFC8;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    a = 16'd7;
    b = 16'd1;
    n = 0;
    while (out_valid !== 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || q !== eq) begin
        errors++;
        $display("[TB] FAIL bp_hold[%0d]: out_valid=%b in_ready=%b q=%h expected 1/0/%h", i, out_valid, in_ready, q, eq);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_release: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_no_queue: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [15:0] qo;
    logic [15:0] ro;
    logic d0o;
    logic ovo;
    @(negedge clk);
    a = 16'd1000;
    b = 16'd3;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rst_mid_hs: out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
    end
    checks++;
    if (q !== 16'h0 || div0 !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_mid_out: q=%h div0=%b ovf=%b expected 0000/0/0", q, div0, ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(16'd9, 16'd3, 0, lat, qo, ro, d0o, ovo);
    checks++;
    if (qo !== 16'd3 || lat !== LAT) begin
      errors++;
      $display("[TB] FAIL rst_mid_after: q=%h lat=%0d expected 0003/%0d", qo, lat, LAT);
    end
  endtask

  task automatic test_throughput();
    logic [15:0] eq;
    logic [15:0] er;
    logic ed0;
    logic eov;
    int rises[$];
    int edge_n;
    logic prev;
    ref_div(16'hB1E7, 16'd13, eq, er, ed0, eov);
    @(negedge clk);
    a = 16'hB1E7;
    b = 16'd13;
    in_valid = 1'b1;
    out_ready = 1'b1;
    prev = 1'b0;
    edge_n = 0;
    while (rises.size() < 3 && edge_n < 200) begin
      @(posedge clk);
      #1;
      edge_n++;
      if (out_valid === 1'b1 && prev !== 1'b1) begin
        rises.push_back(edge_n);
        checks++;
        if (q !== eq) begin
          errors++;
          $display("[TB] FAIL tput_q[%0d]: got %h expected %h", rises.size(), q, eq);
        end
      end
      prev = out_valid;
    end
    checks++;
    if (rises.size() !== 3) begin
      errors++;
      $display("[TB] FAIL tput_count: got %0d results expected 3", rises.size());
    end else begin
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (rises[i] - rises[i-1] !== PER) begin
          errors++;
          $display("[TB] FAIL tput_period[%0d]: got %0d expected %0d", i, rises[i] - rises[i-1], PER);
        end
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (PER + 2) @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_random(input int n_ops);
    logic [15:0] av;
    logic [15:0] bv;
    logic [15:0] eq;
    logic [15:0] er;
    logic ed0;
    logic eov;
    logic [15:0] qo;
    logic [15:0] ro;
    logic d0o;
    logic ovo;
    int lat;
    for (int i = 0; i < n_ops; i++) begin
      av = 16'($urandom);
      bv = 16'($urandom);
      case ($urandom_range(0, 9))
        0: bv = 16'h0000;
        1: begin av = 16'h8000; bv = 16'hFFFF; end
        2: bv = 16'($signed($urandom_range(0, 16)) - 8);
        3: av = 16'h8000;
        4: av = 16'($urandom_range(0, 300));
        default: ;
      endcase
      ref_div(av, bv, eq, er, ed0, eov);
      run_op(av, bv, $urandom_range(0, 3), lat, qo, ro, d0o, ovo);
      checks++;
      if (qo !== eq) begin
        errors++;
        $display("[TB] FAIL rand_q: a=%h b=%h got %h expected %h", av, bv, qo, eq);
      end
      checks++;
      if (d0o !== ed0 || ovo !== eov) begin
        errors++;
        $display("[TB] FAIL rand_flags: a=%h b=%h div0=%b ovf=%b expected %b/%b", av, bv, d0o, ovo, ed0, eov);
      end
      checks++;
      if (lat !== LAT) begin
        errors++;
        $display("[TB] FAIL rand_latency: a=%h b=%h got %0d expected %0d", av, bv, lat, LAT);
      end
`ifdef DIV_REMAINDER_EN
      checks++;
      if (ro !== er) begin
        errors++;
        $display("[TB] FAIL rand_rem: a=%h b=%h got %h expected %h", av, bv, ro, er);
      end
      if (!ed0 && !eov) begin
        checks++;
        if (int'($signed(qo)) * int'($signed(bv)) + int'($signed(ro)) !== int'($signed(av))) begin
          errors++;
          $display("[TB] FAIL rand_invariant: a=%h b=%h q=%h rem=%h", av, bv, qo, ro);
        end
      end
`endif
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_signs();
    test_limits();
    test_backpressure();
    test_reset_mid();
    test_throughput();
    test_random(1500);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
